// File: rtl/onehot_decoder_scan_pkg.sv
// Shared definitions for the one-hot decoder / scanner: mode encodings,
// a constant-evaluable clog2 and an active-high one-hot helper.
package onehot_pkg;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // Widest vector onehot() can produce; callers size-cast down to their width.
  localparam int unsigned ONEHOT_MAX_W = 1024;

  // Ceiling log2; returns 0 for value <= 1.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned w;
    w = 0;
    while ((32'd1 << w) < value) w = w + 1;
    return w;
  endfunction

  // Active-high one-hot vector with bit idx set; all zeros when idx >= width.
  function automatic logic [ONEHOT_MAX_W-1:0] onehot(input int unsigned idx,
                                                      input int unsigned width);
    logic [ONEHOT_MAX_W-1:0] v;
    v = '0;
    if (idx < width) v = {{(ONEHOT_MAX_W-1){1'b0}}, 1'b1} << idx;
    return v;
  endfunction

endpackage

// File: rtl/onehot_decoder_scan_prescaler.sv
// Scan prescaler: free-running 0..DIV-1 counter with synchronous clear and
// hold, producing a one-cycle tick on the terminal count.
module scan_prescaler #(
  parameter int unsigned DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic hold,
  output logic tick
);
  import onehot_pkg::*;

  localparam int unsigned CNT_W = (clog2(DIV) < 1) ? 1 : clog2(DIV);
  localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count: clear wins over hold, otherwise count and wrap at terminal.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (!hold) begin
      cnt_d = (cnt_q == TERMINAL) ? '0 : cnt_q + 1'b1;
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  // A cleared or held counter never steps, even if it sits on the terminal value.
  assign tick = !clr && !hold && (cnt_q == TERMINAL);

endmodule

// File: rtl/onehot_decoder_scan.sv
// Registered one-hot decoder with direct-select and auto-scan modes,
// configurable output count and output polarity.
module onehot_decoder_scan #(
  parameter int unsigned SEL_W      = 4,
  parameter int unsigned OUT_W      = 16,
  parameter int unsigned SCAN_DIV   = 4,
  parameter bit          ACTIVE_LOW = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             mode,
  input  logic [SEL_W-1:0] sel,
  output logic [OUT_W-1:0] y,
  output logic [SEL_W-1:0] idx,
  output logic             wrap,
  output logic             range_err
);
  import onehot_pkg::*;

  // Index arithmetic is one bit wider so OUT_W == 2**SEL_W cannot overflow.
  localparam logic [SEL_W:0]   OUT_COUNT  = (SEL_W + 1)'(OUT_W);
  localparam logic [OUT_W-1:0] Y_INACTIVE = {OUT_W{ACTIVE_LOW}};

  logic             mode_q, mode_d;
  logic [SEL_W-1:0] idx_q, idx_d;
  logic [OUT_W-1:0] y_q, y_d;
  logic             wrap_q, wrap_d;
  logic             range_err_q, range_err_d;

  logic             sel_ok;
  logic             entry;
  logic             scan_clr;
  logic             step;
  logic             active;
  logic [SEL_W:0]   idx_inc;
  logic [OUT_W-1:0] y_onehot;

  assign sel_ok   = ({1'b0, sel} < OUT_COUNT);
  assign entry    = (mode == MODE_SCAN) && (mode_q == MODE_DIRECT);
  // Prescaler sits at 0 in direct mode and restarts on scan entry.
  assign scan_clr = (mode == MODE_DIRECT) || entry;

  scan_prescaler #(
    .DIV (SCAN_DIV)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .clr  (scan_clr),
    .hold (!en),
    .tick (step)
  );

  // Next index, flags and decoded output for direct, entry and scan cycles.
  always_comb begin
    mode_d      = mode;
    idx_d       = idx_q;
    wrap_d      = 1'b0;
    range_err_d = 1'b0;
    active      = 1'b0;
    idx_inc     = {1'b0, idx_q} + 1'b1;

    if (mode == MODE_DIRECT) begin
      if (en && sel_ok) begin
        idx_d  = sel;
        active = 1'b1;
      end else if (en) begin
        range_err_d = 1'b1;
      end
    end else if (entry) begin
      // Entry loads the start channel and suppresses any step this cycle.
      idx_d  = sel_ok ? sel : '0;
      active = en;
    end else if (en) begin
      active = 1'b1;
      if (step) begin
        if (idx_inc == OUT_COUNT) begin
          idx_d  = '0;
          wrap_d = 1'b1;
        end else begin
          idx_d = idx_inc[SEL_W-1:0];
        end
      end
    end

    // Decode from the next index so y and idx register on the same edge.
    y_onehot = OUT_W'(onehot(int'(idx_d), OUT_W));
    y_d      = active ? (y_onehot ^ Y_INACTIVE) : Y_INACTIVE;
  end

  // Output and mode registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q      <= MODE_DIRECT;
      idx_q       <= '0;
      y_q         <= Y_INACTIVE;
      wrap_q      <= 1'b0;
      range_err_q <= 1'b0;
    end else begin
      mode_q      <= mode_d;
      idx_q       <= idx_d;
      y_q         <= y_d;
      wrap_q      <= wrap_d;
      range_err_q <= range_err_d;
    end
  end

  assign y         = y_q;
  assign idx       = idx_q;
  assign wrap      = wrap_q;
  assign range_err = range_err_q;

endmodule
